// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - CPU-side read/error bus of the PS/2 receiver
interface ps2_rx_if;
  logic        rd_en;
  logic        err_clr;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [2:0]  err;

  modport master (output rd_en, err_clr, input rd_data, empty, full, err);
  modport slave  (input rd_en, err_clr, output rd_data, empty, full, err);
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver with filtered clock, deframer and byte FIFO
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     CLK_50MHZ,
  input  logic     reset,
  input  logic     PS2_CLK,
  input  logic     PS2_DATA,
  ps2_rx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  logic [1:0]    clkSync, dataSync;
  logic          filtClk;
  logic [FW-1:0] filtCnt;
  logic          fall, dataBit;

  stateT         state, nextState;
  logic [7:0]    shiftReg;
  logic [2:0]    bitCnt;
  logic [TW-1:0] toCnt;
  logic          timedOut;
  logic          startFrame, shiftEn, parEn, evalEn, stopErr, parErr, pushReq;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wrPtr, rdPtr;
  logic          doPush, doPop, overflow;
  logic [2:0]    errReg;

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      filtClk  <= 1'b1;
      filtCnt  <= '0;
    end else begin
      clkSync  <= {clkSync[0], PS2_CLK};
      dataSync <= {dataSync[0], PS2_DATA};
      if (clkSync[1] == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FW'(FILTER_LEN - 1)) begin
        filtCnt <= '0;
        filtClk <= ~filtClk;
      end else begin
        filtCnt <= filtCnt + 1'b1;
      end
    end
  end

  // Strobe in the cycle whose edge flips the filtered clock low
  assign fall     = filtClk && !clkSync[1] && (filtCnt == FW'(FILTER_LEN - 1));
  assign dataBit  = dataSync[1];
  assign timedOut = (state != IDLE) && !fall && (toCnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (fall && !dataBit)        nextState = DATA;
      DATA:    if (fall && bitCnt == 3'd7)  nextState = PARITY;
      PARITY:  if (fall)                    nextState = STOP;
      STOP:    if (fall)                    nextState = IDLE;
      default:                              nextState = IDLE;
    endcase
    if (timedOut) nextState = IDLE;
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parityBit;
  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset)     parityBit <= 1'b0;
    else if (parEn) parityBit <= dataBit;
  end
`endif

  always_comb begin
    startFrame = (state == IDLE) && fall && !dataBit;
    shiftEn    = (state == DATA) && fall;
    parEn      = (state == PARITY) && fall;
    evalEn     = (state == STOP) && fall;
    stopErr    = evalEn && !dataBit;
`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data plus parity bit must carry an odd number of ones
    parErr     = evalEn && dataBit && !(^{shiftReg, parityBit});
    pushReq    = evalEn && dataBit && (^{shiftReg, parityBit});
`else
    parErr     = 1'b0;
    pushReq    = evalEn && dataBit;
`endif
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      toCnt    <= '0;
    end else begin
      if (startFrame) begin
        shiftReg <= '0;
        bitCnt   <= '0;
      end else if (shiftEn) begin
        shiftReg <= {dataBit, shiftReg[7:1]};
        bitCnt   <= bitCnt + 1'b1;
      end
      if (state == IDLE || fall)           toCnt <= '0;
      else if (toCnt != TW'(TIMEOUT - 1))  toCnt <= toCnt + 1'b1;
    end
  end

  assign bus.empty = (wrPtr == rdPtr);
  assign bus.full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop     = bus.rd_en && !bus.empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign doPush    = pushReq && (!bus.full || doPop);
  assign overflow  = pushReq && bus.full && !doPop;

  always_ff @(posedge CLK_50MHZ) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= shiftReg;
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      errReg <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      errReg <= (errReg & ~{3{bus.err_clr}}) | {overflow, stopErr | timedOut, parErr};
    end
  end

  assign bus.rd_data = bus.empty ? 16'h0000 : {8'h00, mem[rdPtr[AW-1:0]]};
  assign bus.err     = errReg;
endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx (expected bytes queued, monitor checks every read)
module tb_ps2_rx;
  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 20;

  logic clk = 1'b0;
  logic rstN;
  logic ps2Clk, ps2Data;
  int   nTests = 0;
  int   nFail  = 0;
  logic [7:0] expQ[$];

  ps2_rx_if bus();

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK_50MHZ (clk),
    .reset     (rstN),
    .PS2_CLK   (ps2Clk),
    .PS2_DATA  (ps2Data),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic oddPar(input logic [7:0] b);
    return ~^b;
  endfunction

  // Monitor: every accepted read is compared with the oldest expected byte
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.rd_en && !bus.empty) begin
        nTests++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL read_unexpected: got %h, expected no data", bus.rd_data);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          if (bus.rd_data !== {8'h00, e}) begin
            nFail++;
            $display("FAIL read_data: got %h, expected %h", bus.rd_data, {8'h00, e});
          end
        end
      end
    end
  end

  // popAtPush raises rd_en for exactly the cycle in which the stop-bit fall pushes
  task automatic sendBit(input logic b, input bit popAtPush);
    ps2Data = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (popAtPush && i == FILTER_LEN)     bus.rd_en = 1'b1;
      if (popAtPush && i == FILTER_LEN + 1) bus.rd_en = 1'b0;
    end
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic par, input logic stp, input bit popAtPush);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i], 1'b0);
    sendBit(par, 1'b0);
    sendBit(stp, popAtPush);
    ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic goodFrame(input logic [7:0] b, input bit popAtPush);
    expQ.push_back(b);
    sendFrame(b, oddPar(b), 1'b1, popAtPush);
  endtask

  task automatic readOne();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    #1;
  endtask

  task automatic clearErr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_rd_data", bus.rd_data, 16'h0000);
    check("reset_empty", 16'(bus.empty), 16'h1);
    check("reset_full", 16'(bus.full), 16'h0);
    check("reset_err", 16'(bus.err), 16'h0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    goodFrame(8'h1C, 1'b0);
    #1;
    check("good_empty", 16'(bus.empty), 16'h0);
    check("good_rd_data", bus.rd_data, 16'h001C);
    check("good_err", 16'(bus.err), 16'h0);
    readOne();
    check("good_pop_empty", 16'(bus.empty), 16'h1);
    check("good_pop_rd_data", bus.rd_data, 16'h0000);

`ifdef PS2_PARITY_CHECK_EN
    sendFrame(8'h1C, 1'b1, 1'b1, 1'b0);
    #1;
    check("parity_empty", 16'(bus.empty), 16'h1);
    check("parity_err", 16'(bus.err), 16'h1);
    clearErr();
    check("parity_err_clr", 16'(bus.err), 16'h0);
`else
    expQ.push_back(8'h1C);
    sendFrame(8'h1C, 1'b1, 1'b1, 1'b0);
    #1;
    check("noparity_rd_data", bus.rd_data, 16'h001C);
    check("noparity_err", 16'(bus.err), 16'h0);
    readOne();
`endif

    sendFrame(8'hF0, oddPar(8'hF0), 1'b0, 1'b0);
    #1;
    check("framing_empty", 16'(bus.empty), 16'h1);
    check("framing_err", 16'(bus.err), 16'h2);
    clearErr();
    check("framing_err_clr", 16'(bus.err), 16'h0);

    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1, 1'b0);
    ps2Data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    #1;
    check("timeout_err", 16'(bus.err), 16'h2);
    check("timeout_empty", 16'(bus.empty), 16'h1);
    clearErr();
    goodFrame(8'h5A, 1'b0);
    #1;
    check("after_timeout_rd_data", bus.rd_data, 16'h005A);
    check("after_timeout_err", 16'(bus.err), 16'h0);
    readOne();

    for (int i = 1; i <= 4; i++) goodFrame(8'(i), 1'b0);
    #1;
    check("fill_full", 16'(bus.full), 16'h1);
    check("fill_err", 16'(bus.err), 16'h0);
    sendFrame(8'h05, oddPar(8'h05), 1'b1, 1'b0);
    #1;
    check("overflow_err", 16'(bus.err), 16'h4);
    check("overflow_full", 16'(bus.full), 16'h1);
    for (int i = 0; i < 4; i++) readOne();
    check("drain_empty", 16'(bus.empty), 16'h1);
    clearErr();

    for (int i = 1; i <= 4; i++) goodFrame(8'(i), 1'b0);
    goodFrame(8'h06, 1'b1);
    #1;
    check("simul_full", 16'(bus.full), 16'h1);
    check("simul_err", 16'(bus.err), 16'h0);
    for (int i = 0; i < 4; i++) readOne();
    check("simul_drain_empty", 16'(bus.empty), 16'h1);

    @(negedge clk);
    ps2Data = 1'b0;
    ps2Clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (5) @(negedge clk);
    ps2Data = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("glitch_empty", 16'(bus.empty), 16'h1);
    check("glitch_err", 16'(bus.err), 16'h0);
    goodFrame(8'h11, 1'b0);
    #1;
    check("post_glitch_rd_data", bus.rd_data, 16'h0011);

    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(i[0], 1'b0);
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("midreset_rd_data", bus.rd_data, 16'h0000);
    check("midreset_empty", 16'(bus.empty), 16'h1);
    check("midreset_full", 16'(bus.full), 16'h0);
    check("midreset_err", 16'(bus.err), 16'h0);
    expQ.delete();
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    goodFrame(8'h29, 1'b0);
    #1;
    check("post_reset_rd_data", bus.rd_data, 16'h0029);
    check("post_reset_err", 16'(bus.err), 16'h0);
    readOne();
    check("final_queue_drained", 16'(expQ.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 device-to-host receiver that gives the CPU keyboard input alongside the LCD output path. It samples the board PS2_CLK/PS2_DATA lines and filters and deframes 11-bit PS/2 frames. Received bytes go into a small FIFO that the CPU reads as zero-extended 16-bit words over its data bus. Host-to-device transmission is out of scope.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered PS2_CLK changes.
- TIMEOUT, 50000: idle cycles (1 ms at 50 MHz) after which a partial frame is aborted.
- FIFO_DEPTH, 4: byte FIFO depth; power of 2, ≥2.

Ports:
- CLK_50MHZ  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- PS2_CLK  input  1  raw PS/2 clock pin, asynchronous.
- PS2_DATA  input  1  raw PS/2 data pin, asynchronous.
- rd_en  input  1  pop FIFO head this cycle.
- err_clr  input  1  clear all sticky error bits.
- rd_data  output  16  {8'h00, FIFO head}; 16'h0000 when empty.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- err  output  3  sticky {overflow, framing, parity}.

## Operation
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-flop synchronizer.
  - Synchronized clock feeds a filter: the filtered level flips only after FILTER_LEN consecutive cycles at the new level. Filtered level resets to 1.
  - A filtered 1→0 transition is a "fall" (1-cycle strobe). On a fall, the bit sampled is the synchronized PS2_DATA from that cycle.
- FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0 (start bit), clear the shift register and bit count, then go to DATA. A fall with data=1 is ignored.
  - DATA: on each fall, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on a fall, store the bit and go to STOP.
  - STOP: on a fall, evaluate the frame and return to IDLE.
- Frame evaluation, in priority order:
  1. Stop bit 0: set err[1], drop the byte.
  2. Parity bad (the 8 data bits plus the parity bit have even weight): set err[0], drop the byte (see Configuration).
  3. Otherwise push the byte into the FIFO.
- Timeout: a counter clears on every fall and in IDLE. In DATA/PARITY/STOP, if it reaches TIMEOUT-1, set err[1] and force IDLE; the partial byte is discarded.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; wrap is the MSB difference. First-word-fall-through: rd_data is the head, combinational from storage.
  - rd_en while empty: ignored, no error.
  - Push while full with no rd_en: byte dropped, err[2] set.
  - Push and rd_en in the same cycle (including when full): both happen, occupancy unchanged, no overflow.
- err bits are sticky. err_clr clears them. If err_clr and a new error happen in the same cycle, the new error wins (bit reads 1).

## Timing
- Reset values:
  - Outputs: rd_data=16'h0000, empty=1, full=0, err=3'b000.
  - Internal: FSM=IDLE, pointers 0, filtered clock 1, synchronizers 1.
- Reset takes effect immediately and asynchronously. Reset mid-frame discards the partial frame and all FIFO contents.
- Fall latency: 2 (sync) + FILTER_LEN cycles after the pin edge.
- Push happens on the cycle of the stop-bit fall. On the next clock edge, empty falls and rd_data is valid.
- Pop: at the clock edge where rd_en=1, the head advances. rd_data, empty, and full update on that same edge.
- err bits update on the clock edge at which the error condition is evaluated.
- Pulses on PS2_CLK shorter than FILTER_LEN cycles produce no fall.

## Configuration
- PS2_PARITY_CHECK_EN defined:
  - Parity is checked as described.
  - Bad-parity bytes are dropped and set err[0].
- Not defined:
  - The parity bit is still clocked through the PARITY state but not checked.
  - Frames with a valid stop bit are always pushed.
  - err[0] is tied to 0.

## Test plan
Bit period is 40 µs (2000 cycles) unless stated.
- Good frame: byte 8'h1C with odd parity bit 0, stop 1 -> empty=0, rd_data=16'h001C, err=0. Then rd_en for 1 cycle -> empty=1, rd_data=16'h0000.
- Parity (macro defined): byte 8'h1C with parity bit 1 -> empty stays 1, err=3'b001. Then err_clr -> err=0. With the macro undefined, the same frame -> rd_data=16'h001C, err=0.
- Framing: byte 8'hF0 with stop bit 0 -> no push, err=3'b010. Separately, 4 data bits then idle for TIMEOUT cycles -> err[1]=1, FSM back in IDLE. A following good frame 8'h5A -> rd_data=16'h005A.
- Overflow/order: 5 good frames 8'h01..8'h05, no reads -> full=1 after the 4th, err=3'b100 after the 5th. Four reads -> 16'h0001..16'h0004, then empty=1.
- Simultaneous: with the FIFO full, assert rd_en on the push cycle of 8'h06 -> full stays 1, err[2] stays 0, next four reads -> 02,03,04,06.
- Glitch/reset: a 3-cycle low pulse on PS2_CLK -> no state change. Asserting reset (low) mid-frame after 5 bits, then releasing -> all outputs at reset values. The next good frame 8'h29 -> rd_data=16'h0029.
